// File: rtl/key_step_pkg.sv
// Shared types and defaults for the pushbutton step sequencer feeding the sequential ALU.
package key_step_pkg;

    localparam int DATA_W_DEF = 4;
    localparam int FUNC_W_DEF = 2;

    // ALU Function code, also used by the ALU stage.
    typedef logic [1:0] alu_func_t;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_PEND   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_PEND = 2'd3
    } deb_state_e;

    function automatic logic level_of(input deb_state_e s);
        return (s == PRESSED) || (s == RELEASE_PEND);
    endfunction

endpackage

// File: rtl/key_step_sequencer_debounce.sv
// Two-flop synchroniser and debounce FSM for an active-low pushbutton; emits one
// press_evt_o per clean press and a registered debounced level.
module button_debounce
    import key_step_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       key_n_i,
    output logic       press_evt_o,
    output logic       key_level_o,
    output deb_state_e state_o
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    deb_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          armed_q, armed_d;
    logic          level_q;
    logic          key_sync;

    assign key_sync = sync2_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= RELEASED;
            cnt_q   <= '0;
            armed_q <= 1'b0;
            level_q <= 1'b0;
        end else begin
            sync1_q <= key_n_i;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
            level_q <= level_of(state_d);
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        armed_d     = armed_q;
        press_evt_o = 1'b0;
        case (state_q)
            RELEASED: begin
                // After reset a press is only recognised once the key has been seen
                // released for a full debounce window; both flops must agree so the
                // reset value of the synchroniser cannot count as a release.
                if (!armed_q) begin
                    if (sync1_q && sync2_q) begin
                        if (cnt_q == LAST) begin
                            armed_d = 1'b1;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end else if (!key_sync) begin
                    state_d = PRESS_PEND;
                    cnt_d   = CW'(1);
                end else begin
                    cnt_d = '0;
                end
            end
            PRESS_PEND: begin
                if (key_sync) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == LAST) begin
                    state_d     = PRESSED;
                    cnt_d       = '0;
                    press_evt_o = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                if (key_sync) begin
                    state_d = RELEASE_PEND;
                    cnt_d   = CW'(1);
                end
            end
            RELEASE_PEND: begin
                if (!key_sync) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == LAST) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

    assign key_level_o = level_q;
    assign state_o     = state_q;

endmodule

// File: rtl/key_step_sequencer.sv
// Turns each debounced button press into one command (synchronised Data/Function
// switches) presented on a valid/ready handshake to the sequential ALU.
module key_step_sequencer
    import key_step_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DATA_W          = DATA_W_DEF,
    parameter int FUNC_W          = FUNC_W_DEF,
    parameter int CNT_W           = 8
) (
    input  logic              Clock,
    input  logic              Reset_b,
    input  logic              key_n_raw,
    input  logic [DATA_W-1:0] sw_data,
    input  logic [FUNC_W-1:0] sw_func,
    input  logic              clr_overrun,
    input  logic              cmd_ready,
    output logic              cmd_valid,
    output logic [DATA_W-1:0] cmd_data,
    output logic [FUNC_W-1:0] cmd_func,
    output logic              overrun,
    output logic [CNT_W-1:0]  cmd_count,
    output logic              key_level,
    output logic [1:0]        deb_state
);

    // Handshake: a command transfers on any edge where cmd_valid and cmd_ready are
    // both 1; cmd_data/cmd_func hold steady while cmd_valid is 1, and cmd_ready is
    // ignored while cmd_valid is 0.

    logic [DATA_W-1:0] data_s1_q, data_s2_q;
    logic [FUNC_W-1:0] func_s1_q, func_s2_q;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [FUNC_W-1:0] func_q, func_d;
    logic              ovr_q, ovr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              press_evt;
    logic              xfer, load, drop;
    deb_state_e        deb_state_w;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk_i      (Clock),
        .rst_n_i    (Reset_b),
        .key_n_i    (key_n_raw),
        .press_evt_o(press_evt),
        .key_level_o(key_level),
        .state_o    (deb_state_w)
    );

    assign xfer = valid_q && cmd_ready;
    assign load = press_evt && (!valid_q || cmd_ready);
    assign drop = press_evt && valid_q && !cmd_ready;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        func_d  = func_q;
        ovr_d   = ovr_q;
        count_d = count_q;
        if (xfer) begin
            valid_d = 1'b0;
            count_d = count_q + 1'b1;
        end
        // A load in the same cycle as a transfer keeps cmd_valid high.
        if (load) begin
            valid_d = 1'b1;
            data_d  = data_s2_q;
            func_d  = func_s2_q;
        end
        if (drop) begin
            ovr_d = 1'b1;
        end else if (clr_overrun) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset_b) begin
            data_s1_q <= '0;
            data_s2_q <= '0;
            func_s1_q <= '0;
            func_s2_q <= '0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            func_q    <= '0;
            ovr_q     <= 1'b0;
            count_q   <= '0;
        end else begin
            data_s1_q <= sw_data;
            data_s2_q <= data_s1_q;
            func_s1_q <= sw_func;
            func_s2_q <= func_s1_q;
            valid_q   <= valid_d;
            data_q    <= data_d;
            func_q    <= func_d;
            ovr_q     <= ovr_d;
            count_q   <= count_d;
        end
    end

    assign cmd_valid = valid_q;
    assign cmd_data  = data_q;
    assign cmd_func  = func_q;
    assign overrun   = ovr_q;
    assign cmd_count = count_q;
    assign deb_state = deb_state_w;

endmodule

// File: tb/tb_key_step_sequencer.sv
// Directed bench for key_step_sequencer with a 4-cycle debounce window.
module tb_key_step_sequencer;

    logic       Clock = 1'b0;
    logic       Reset_b;
    logic       key_n_raw;
    logic [3:0] sw_data;
    logic [1:0] sw_func;
    logic       clr_overrun;
    logic       cmd_ready;
    logic       cmd_valid;
    logic [3:0] cmd_data;
    logic [1:0] cmd_func;
    logic       overrun;
    logic [7:0] cmd_count;
    logic       key_level;
    logic [1:0] deb_state;

    int total = 0;
    int bad   = 0;

    key_step_sequencer #(
        .DEBOUNCE_CYCLES(4),
        .DATA_W(4),
        .FUNC_W(2),
        .CNT_W(8)
    ) dut (
        .Clock      (Clock),
        .Reset_b    (Reset_b),
        .key_n_raw  (key_n_raw),
        .sw_data    (sw_data),
        .sw_func    (sw_func),
        .clr_overrun(clr_overrun),
        .cmd_ready  (cmd_ready),
        .cmd_valid  (cmd_valid),
        .cmd_data   (cmd_data),
        .cmd_func   (cmd_func),
        .overrun    (overrun),
        .cmd_count  (cmd_count),
        .key_level  (key_level),
        .deb_state  (deb_state)
    );

    always #5 Clock = ~Clock;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic release_key();
        key_n_raw = 1'b1;
        cyc(8);
    endtask

    initial begin
        Reset_b     = 1'b0;
        key_n_raw   = 1'b0;
        sw_data     = 4'h0;
        sw_func     = 2'b00;
        clr_overrun = 1'b0;
        cmd_ready   = 1'b0;

        // Reset with key held
        cyc(3);
        chk("rst_valid", 32'(cmd_valid), 32'd0);
        chk("rst_data", 32'(cmd_data), 32'd0);
        chk("rst_func", 32'(cmd_func), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        chk("rst_count", 32'(cmd_count), 32'd0);
        chk("rst_level", 32'(key_level), 32'd0);
        Reset_b = 1'b1;
        cyc(10);
        chk("held_after_rst_valid", 32'(cmd_valid), 32'd0);
        chk("held_after_rst_level", 32'(key_level), 32'd0);
        chk("held_after_rst_state", 32'(deb_state), 32'd0);

        // Clean press, exact latency
        key_n_raw = 1'b1;
        sw_data   = 4'hA;
        sw_func   = 2'b01;
        cyc(10);
        chk("arm_no_cmd", 32'(cmd_valid), 32'd0);
        key_n_raw = 1'b0;
        cyc(5);
        chk("press_lat5_valid", 32'(cmd_valid), 32'd0);
        chk("press_lat5_level", 32'(key_level), 32'd0);
        cyc(1);
        chk("press_lat6_valid", 32'(cmd_valid), 32'd1);
        chk("press_data", 32'(cmd_data), 32'hA);
        chk("press_func", 32'(cmd_func), 32'd1);
        chk("press_level", 32'(key_level), 32'd1);
        chk("press_count", 32'(cmd_count), 32'd0);
        chk("press_state", 32'(deb_state), 32'd2);
        sw_data = 4'h5;
        cyc(10);
        chk("hold_valid", 32'(cmd_valid), 32'd1);
        chk("hold_data", 32'(cmd_data), 32'hA);
        chk("hold_ovr", 32'(overrun), 32'd0);

        // Release latency of the debounced level
        key_n_raw = 1'b1;
        cyc(5);
        chk("rel_lat5_level", 32'(key_level), 32'd1);
        cyc(1);
        chk("rel_lat6_level", 32'(key_level), 32'd0);
        cyc(2);

        // Handshake: one-cycle ready
        cmd_ready = 1'b1;
        cyc(1);
        cmd_ready = 1'b0;
        chk("hs_valid_drop", 32'(cmd_valid), 32'd0);
        chk("hs_count", 32'(cmd_count), 32'd1);
        cmd_ready = 1'b1;
        cyc(2);
        cmd_ready = 1'b0;
        chk("hs_ready_ignored", 32'(cmd_count), 32'd1);
        sw_data   = 4'h3;
        key_n_raw = 1'b0;
        cyc(6);
        chk("hs2_valid", 32'(cmd_valid), 32'd1);
        chk("hs2_data", 32'(cmd_data), 32'h3);
        release_key();
        cmd_ready = 1'b1;
        cyc(1);
        cmd_ready = 1'b0;
        chk("hs2_count", 32'(cmd_count), 32'd2);

        // Bounce: 2-cycle toggles, then steady press
        sw_data = 4'h7;
        for (int k = 0; k < 10; k++) begin
            key_n_raw = (k % 2 == 0) ? 1'b0 : 1'b1;
            cyc(2);
        end
        chk("bounce_valid", 32'(cmd_valid), 32'd0);
        chk("bounce_level", 32'(key_level), 32'd0);
        key_n_raw = 1'b0;
        cyc(5);
        chk("bounce_lat5_level", 32'(key_level), 32'd0);
        cyc(1);
        chk("bounce_lat6_level", 32'(key_level), 32'd1);
        chk("bounce_valid_on", 32'(cmd_valid), 32'd1);
        chk("bounce_data", 32'(cmd_data), 32'h7);
        cmd_ready = 1'b1;
        cyc(1);
        cmd_ready = 1'b0;
        cyc(10);
        chk("bounce_single_valid", 32'(cmd_valid), 32'd0);
        chk("bounce_single_count", 32'(cmd_count), 32'd3);
        release_key();

        // Overrun
        sw_data   = 4'h9;
        key_n_raw = 1'b0;
        cyc(6);
        chk("ovr_first_valid", 32'(cmd_valid), 32'd1);
        release_key();
        sw_data   = 4'h6;
        key_n_raw = 1'b0;
        cyc(5);
        chk("ovr_pre", 32'(overrun), 32'd0);
        cyc(1);
        chk("ovr_set", 32'(overrun), 32'd1);
        chk("ovr_kept_data", 32'(cmd_data), 32'h9);
        chk("ovr_kept_valid", 32'(cmd_valid), 32'd1);
        release_key();
        clr_overrun = 1'b1;
        cyc(1);
        clr_overrun = 1'b0;
        chk("ovr_clr", 32'(overrun), 32'd0);
        // Drop and clear on the same edge: set wins
        key_n_raw = 1'b0;
        cyc(5);
        clr_overrun = 1'b1;
        cyc(1);
        clr_overrun = 1'b0;
        chk("ovr_set_wins", 32'(overrun), 32'd1);
        release_key();
        clr_overrun = 1'b1;
        cyc(1);
        clr_overrun = 1'b0;
        chk("ovr_clr2", 32'(overrun), 32'd0);

        // Press coincident with a transfer
        sw_data   = 4'hC;
        sw_func   = 2'b10;
        key_n_raw = 1'b0;
        cyc(5);
        cmd_ready = 1'b1;
        cyc(1);
        cmd_ready = 1'b0;
        chk("b2b_valid", 32'(cmd_valid), 32'd1);
        chk("b2b_data", 32'(cmd_data), 32'hC);
        chk("b2b_func", 32'(cmd_func), 32'd2);
        chk("b2b_ovr", 32'(overrun), 32'd0);
        chk("b2b_count", 32'(cmd_count), 32'd4);
        release_key();
        cmd_ready = 1'b1;
        cyc(1);
        cmd_ready = 1'b0;
        chk("b2b_accept_count", 32'(cmd_count), 32'd5);

        // Counter wrap
        for (int i = 0; i < 250; i++) begin
            sw_data   = 4'(i);
            key_n_raw = 1'b0;
            cyc(6);
            chk("wrap_data", 32'(cmd_data), 32'(i % 16));
            cmd_ready = 1'b1;
            cyc(1);
            cmd_ready = 1'b0;
            chk("wrap_count", 32'(cmd_count), 32'((6 + i) % 256));
            key_n_raw = 1'b1;
            cyc(7);
        end
        chk("wrap_255", 32'(cmd_count), 32'd255);
        key_n_raw = 1'b0;
        cyc(6);
        cmd_ready = 1'b1;
        cyc(1);
        cmd_ready = 1'b0;
        chk("wrap_zero", 32'(cmd_count), 32'd0);
        release_key();

        // Reset with a pending command and mid-debounce
        sw_data   = 4'h2;
        key_n_raw = 1'b0;
        cyc(6);
        chk("mid_pending", 32'(cmd_valid), 32'd1);
        release_key();
        key_n_raw = 1'b0;
        cyc(3);
        Reset_b = 1'b0;
        cyc(2);
        Reset_b = 1'b1;
        cyc(10);
        chk("mid_rst_valid", 32'(cmd_valid), 32'd0);
        chk("mid_rst_count", 32'(cmd_count), 32'd0);
        chk("mid_rst_level", 32'(key_level), 32'd0);
        key_n_raw = 1'b1;
        cyc(10);
        sw_data   = 4'hE;
        key_n_raw = 1'b0;
        cyc(6);
        chk("post_rst_valid", 32'(cmd_valid), 32'd1);
        chk("post_rst_data", 32'(cmd_data), 32'hE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
